i2c_regif_slave: RTL and testbench

- I2C target (responder) that terminates the tagged-byte protocol the flasher I2C master emits.
- Each byte is {2-bit tag, 6-bit payload}. A tag of `A_ADDR loads the register pointer. A tag of `D_ADDR writes the payload to the register at the pointer.
- Read transfers return {`D_ADDR, register contents}.
- Sits between the top-level SCL/SDA pad tristate and the flasher register file (LED mode and similar registers).

---
 rtl/i2c_regif_slave.sv | 192 +++++++++++++++++++
 tb/tb_i2c_regif_slave.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_regif_slave.sv
// I2C target for the flasher's tagged-byte register protocol.
// Bytes are {tag, payload}. The A tag loads the pointer and the D tag writes at it.
module i2c_regif_slave #(
   parameter logic [6:0] I2C_ADDR  = 7'h41,
   parameter int         DATA_BITS = 6,
   parameter bit         LSB_FIRST = 1'b0
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 SCL_I,
   input  logic                 SDA_I,
   output logic                 SDA_OE,
   output logic [DATA_BITS-1:0] REG_ADDR,
   output logic [DATA_BITS-1:0] REG_WDATA,
   output logic                 REG_WE,
   input  logic [DATA_BITS-1:0] REG_RDATA,
   output logic                 REG_RE,
   output logic                 BUSY
);

   localparam logic [1:0] TAG_A = 2'b01;
   localparam logic [1:0] TAG_D = 2'b10;
   localparam logic [DATA_BITS-1:0] ONE = 1;

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_DEC, S_RX_WAIT,
      S_RX_ACK, S_TX_LOAD, S_TX, S_TX_ACK, S_WAIT_STOP
   } state_t;

   state_t               state_q, state_d;
   logic [2:0]           scl_q, sda_q;
   logic [3:0]           cnt_q, cnt_d;
   logic [7:0]           sh_q, sh_d;
   logic                 oe_q, oe_d;
   logic                 we_q, we_d;
   logic [DATA_BITS-1:0] addr_q, addr_d;
   logic [DATA_BITS-1:0] wdata_q, wdata_d;

   logic scl_s, sda_s, scl_rise, scl_fall, start, stop;
   logic [7:0] rx_sh, tx_sh, tx_new;

   // [0],[1] synchronise; [2] is the history flop for edge detection
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         scl_q <= 3'b111;
         sda_q <= 3'b111;
      end else begin
         scl_q <= {scl_q[1:0], SCL_I};
         sda_q <= {sda_q[1:0], SDA_I};
      end
   end

   assign scl_s    = scl_q[1];
   assign sda_s    = sda_q[1];
   assign scl_rise = scl_s & ~scl_q[2];
   assign scl_fall = ~scl_s & scl_q[2];
   assign start    = scl_s & scl_q[2] & sda_q[2] & ~sda_s;
   assign stop     = scl_s & scl_q[2] & ~sda_q[2] & sda_s;

   assign rx_sh  = LSB_FIRST ? {sda_s, sh_q[7:1]} : {sh_q[6:0], sda_s};
   assign tx_sh  = LSB_FIRST ? {1'b0, sh_q[7:1]} : {sh_q[6:0], 1'b0};
   assign tx_new = {TAG_D, REG_RDATA};

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         oe_q    <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         oe_q    <= oe_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      oe_d    = oe_q;
      we_d    = 1'b0;
      wdata_d = wdata_q;
      addr_d  = we_q ? addr_q + ONE : addr_q;
      unique case (state_q)
         S_IDLE: ;
         S_ADDR: begin
            if (scl_rise) begin
               sh_d  = rx_sh;
               cnt_d = cnt_q + 4'd1;
            end else if (scl_fall && cnt_q == 4'd8) begin
               if (sh_q[7:1] == I2C_ADDR) begin
                  state_d = S_ADDR_ACK;
                  oe_d    = 1'b1;
               end else begin
                  state_d = S_WAIT_STOP;
               end
            end
         end
         S_ADDR_ACK: begin
            if (scl_fall) begin
               oe_d    = 1'b0;
               cnt_d   = '0;
               state_d = sh_q[0] ? S_TX_LOAD : S_RX;
            end
         end
         S_RX: begin
            if (scl_rise) begin
               sh_d  = rx_sh;
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd7) state_d = S_RX_DEC;
            end
         end
         S_RX_DEC: begin
            cnt_d   = '0;
            state_d = S_RX_WAIT;
            if (sh_q[7:6] == TAG_A) begin
               addr_d = sh_q[DATA_BITS-1:0];
            end else if (sh_q[7:6] == TAG_D) begin
               we_d    = 1'b1;
               wdata_d = sh_q[DATA_BITS-1:0];
            end
         end
         S_RX_WAIT: begin
            if (scl_fall) begin
               oe_d    = 1'b1;
               state_d = S_RX_ACK;
            end
         end
         S_RX_ACK: begin
            if (scl_fall) begin
               oe_d    = 1'b0;
               state_d = S_RX;
            end
         end
         S_TX_LOAD: begin
            sh_d    = tx_new;
            addr_d  = addr_q + ONE;
            oe_d    = LSB_FIRST ? ~tx_new[0] : ~tx_new[7];
            cnt_d   = '0;
            state_d = S_TX;
         end
         S_TX: begin
            if (scl_fall) begin
               if (cnt_q == 4'd7) begin
                  oe_d    = 1'b0;
                  cnt_d   = '0;
                  state_d = S_TX_ACK;
               end else begin
                  cnt_d = cnt_q + 4'd1;
                  sh_d  = tx_sh;
                  oe_d  = LSB_FIRST ? ~tx_sh[0] : ~tx_sh[7];
               end
            end
         end
         S_TX_ACK: begin
            // next byte is loaded only once SCL is low again
            if (scl_rise) begin
               if (sda_s) state_d = S_WAIT_STOP;
               else       cnt_d   = 4'd1;
            end else if (scl_fall && cnt_q == 4'd1) begin
               state_d = S_TX_LOAD;
            end
         end
         S_WAIT_STOP: oe_d = 1'b0;
         default: state_d = S_IDLE;
      endcase
      if (start) begin
         state_d = S_ADDR;
         cnt_d   = '0;
         oe_d    = 1'b0;
      end else if (stop) begin
         state_d = S_IDLE;
         oe_d    = 1'b0;
      end
   end

   assign SDA_OE    = oe_q;
   assign REG_ADDR  = addr_q;
   assign REG_WDATA = wdata_q;
   assign REG_WE    = we_q;
   assign REG_RE    = (state_q == S_TX_LOAD);
   assign BUSY      = (state_q != S_IDLE);

endmodule

// File: tb/tb_i2c_regif_slave.sv
// Directed bench for i2c_regif_slave: one MSB-first and one LSB-first
// instance on separate buses, driven by a bit-banged master.
module tb_i2c_regif_slave;

   localparam time Q = 500ns;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic scl_m = 1'b1;
   logic sda_m = 1'b1;
   logic sel = 1'b0;
   always #25ns clk = ~clk;

   logic       oe0, we0, re0, busy0;
   logic       oe1, we1, re1, busy1;
   logic [5:0] addr0, wd0, rd0;
   logic [5:0] addr1, wd1, rd1;
   logic [5:0] mem [64];

   wire bus_sda = sel ? (sda_m & ~oe1) : (sda_m & ~oe0);
   wire scl0 = sel ? 1'b1 : scl_m;
   wire sda0 = sel ? 1'b1 : bus_sda;
   wire scl1 = sel ? scl_m : 1'b1;
   wire sda1 = sel ? bus_sda : 1'b1;

   assign rd0 = mem[addr0];
   assign rd1 = mem[addr1];

   i2c_regif_slave #(.I2C_ADDR(7'h41), .DATA_BITS(6), .LSB_FIRST(1'b0)) u0 (
      .CLK(clk), .RST(rst), .SCL_I(scl0), .SDA_I(sda0), .SDA_OE(oe0),
      .REG_ADDR(addr0), .REG_WDATA(wd0), .REG_WE(we0),
      .REG_RDATA(rd0), .REG_RE(re0), .BUSY(busy0)
   );

   i2c_regif_slave #(.I2C_ADDR(7'h41), .DATA_BITS(6), .LSB_FIRST(1'b1)) u1 (
      .CLK(clk), .RST(rst), .SCL_I(scl1), .SDA_I(sda1), .SDA_OE(oe1),
      .REG_ADDR(addr1), .REG_WDATA(wd1), .REG_WE(we1),
      .REG_RDATA(rd1), .REG_RE(re1), .BUSY(busy1)
   );

   wire       m_we   = sel ? we1 : we0;
   wire       m_re   = sel ? re1 : re0;
   wire       m_oe   = sel ? oe1 : oe0;
   wire       m_busy = sel ? busy1 : busy0;
   wire [5:0] m_addr = sel ? addr1 : addr0;
   wire [5:0] m_wd   = sel ? wd1 : wd0;

   int         checks = 0;
   int         failures = 0;
   int         we_cnt, re_cnt, busy_drop;
   logic [5:0] we_a [8];
   logic [5:0] we_d [8];
   logic       oe_seen, both_hi, track;

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 6'(i);
      mem[4] = 6'h15;
      mem[5] = 6'h2C;
      mem[7] = 6'h33;
      both_hi = 1'b0;
      track = 1'b0;
   end

   always @(posedge clk) begin
      if (m_we) begin
         if (we_cnt < 8) begin
            we_a[we_cnt] = m_addr;
            we_d[we_cnt] = m_wd;
         end
         we_cnt++;
      end
      if (m_re) re_cnt++;
      if (m_oe) oe_seen = 1'b1;
      if ((we0 && re0) || (we1 && re1)) both_hi = 1'b1;
      if (track && !m_busy) busy_drop++;
   end

   task automatic clr_mon();
      we_cnt = 0;
      re_cnt = 0;
      busy_drop = 0;
      oe_seen = 1'b0;
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; #Q;
      scl_m = 1'b1; #Q;
      sda_m = 1'b0; #Q;
      scl_m = 1'b0; #Q;
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; #Q;
      scl_m = 1'b1; #Q;
      sda_m = 1'b1; #Q;
   endtask

   task automatic write_bit(input logic b);
      sda_m = b; #Q;
      scl_m = 1'b1; #(2*Q);
      scl_m = 1'b0; #Q;
   endtask

   task automatic read_bit(output logic b);
      sda_m = 1'b1; #Q;
      scl_m = 1'b1; #Q;
      b = bus_sda; #Q;
      scl_m = 1'b0; #Q;
   endtask

   task automatic send_bits(input logic [7:0] d, input bit lsb);
      for (int i = 0; i < 8; i++) write_bit(lsb ? d[i] : d[7-i]);
   endtask

   task automatic write_byte(input logic [7:0] d, input bit lsb,
                             output logic ack);
      send_bits(d, lsb);
      read_bit(ack);
   endtask

   task automatic read_byte(input logic ackbit, input bit lsb,
                            output logic [7:0] d);
      logic b;
      d = '0;
      for (int i = 0; i < 8; i++) begin
         read_bit(b);
         if (lsb) d[i] = b;
         else     d = {d[6:0], b};
      end
      write_bit(ackbit);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #(4*Q);
      checks++;
      if ({oe0, we0, re0, busy0, addr0, wd0} !== 16'h0) begin
         failures++;
         $display("FAIL reset_outputs: got %h want 0000",
                  {oe0, we0, re0, busy0, addr0, wd0});
      end
      @(negedge clk);
      rst = 1'b0;
      #Q;
   endtask

   task automatic test_write();
      logic a0, a1, a2;
      sel = 1'b0;
      clr_mon();
      i2c_start();
      write_byte(8'h82, 1'b0, a0);
      write_byte(8'h42, 1'b0, a1);
      write_byte(8'h81, 1'b0, a2);
      checks++;
      if ({a0, a1, a2} !== 3'b000) begin
         failures++;
         $display("FAIL write_acks: got %b want 000", {a0, a1, a2});
      end
      checks++;
      if (busy0 !== 1'b1) begin
         failures++;
         $display("FAIL write_busy: got %b want 1", busy0);
      end
      i2c_stop();
      #Q;
      checks++;
      if (busy0 !== 1'b0) begin
         failures++;
         $display("FAIL write_busy_stop: got %b want 0", busy0);
      end
      checks++;
      if (we_cnt !== 1 || we_a[0] !== 6'd2 || we_d[0] !== 6'd1) begin
         failures++;
         $display("FAIL write_we: got n=%0d a=%0d d=%0d want n=1 a=2 d=1",
                  we_cnt, we_a[0], we_d[0]);
      end
      checks++;
      if (addr0 !== 6'd3) begin
         failures++;
         $display("FAIL write_ptr: got %0d want 3", addr0);
      end
   endtask

   task automatic test_mismatch();
      logic a0, a1, a2;
      clr_mon();
      i2c_start();
      write_byte(8'h84, 1'b0, a0);
      write_byte(8'h42, 1'b0, a1);
      write_byte(8'h81, 1'b0, a2);
      i2c_stop();
      #Q;
      checks++;
      if ({a0, a1, a2} !== 3'b111) begin
         failures++;
         $display("FAIL mismatch_acks: got %b want 111", {a0, a1, a2});
      end
      checks++;
      if (oe_seen !== 1'b0 || we_cnt !== 0) begin
         failures++;
         $display("FAIL mismatch_quiet: got oe=%b we=%0d want oe=0 we=0",
                  oe_seen, we_cnt);
      end
      checks++;
      if (busy0 !== 1'b0 || addr0 !== 6'd3) begin
         failures++;
         $display("FAIL mismatch_idle: got busy=%b ptr=%0d want 0 3",
                  busy0, addr0);
      end
   endtask

   task automatic test_wrap();
      logic a0, a1, a2, a3;
      clr_mon();
      i2c_start();
      write_byte(8'h82, 1'b0, a0);
      write_byte(8'h7F, 1'b0, a1);
      write_byte(8'h85, 1'b0, a2);
      write_byte(8'h86, 1'b0, a3);
      i2c_stop();
      #Q;
      checks++;
      if ({a0, a1, a2, a3} !== 4'b0000 || we_cnt !== 2) begin
         failures++;
         $display("FAIL wrap_count: got ack=%b n=%0d want 0000 2",
                  {a0, a1, a2, a3}, we_cnt);
      end
      checks++;
      if (we_a[0] !== 6'd63 || we_d[0] !== 6'd5 ||
          we_a[1] !== 6'd0 || we_d[1] !== 6'd6) begin
         failures++;
         $display("FAIL wrap_we: got %0d/%0d %0d/%0d want 63/5 0/6",
                  we_a[0], we_d[0], we_a[1], we_d[1]);
      end
      checks++;
      if (addr0 !== 6'd1) begin
         failures++;
         $display("FAIL wrap_ptr: got %0d want 1", addr0);
      end
   endtask

   task automatic test_read();
      logic a0, a1;
      logic [7:0] b0, b1;
      i2c_start();
      write_byte(8'h82, 1'b0, a0);
      write_byte(8'h44, 1'b0, a1);
      i2c_stop();
      clr_mon();
      i2c_start();
      write_byte(8'h83, 1'b0, a0);
      read_byte(1'b0, 1'b0, b0);
      read_byte(1'b1, 1'b0, b1);
      checks++;
      if (b0 !== 8'h95 || b1 !== 8'hAC) begin
         failures++;
         $display("FAIL read_data: got %h %h want 95 ac", b0, b1);
      end
      checks++;
      if (oe0 !== 1'b0 || busy0 !== 1'b1) begin
         failures++;
         $display("FAIL read_waitstop: got oe=%b busy=%b want 0 1",
                  oe0, busy0);
      end
      i2c_stop();
      #Q;
      checks++;
      if (re_cnt !== 2 || addr0 !== 6'd6) begin
         failures++;
         $display("FAIL read_re: got re=%0d ptr=%0d want 2 6",
                  re_cnt, addr0);
      end
   endtask

   task automatic test_rstart();
      logic a0, a1, a2;
      logic [7:0] b0;
      clr_mon();
      i2c_start();
      track = 1'b1;
      write_byte(8'h82, 1'b0, a0);
      write_byte(8'h47, 1'b0, a1);
      i2c_start();
      write_byte(8'h83, 1'b0, a2);
      read_byte(1'b1, 1'b0, b0);
      track = 1'b0;
      i2c_stop();
      #Q;
      checks++;
      if (b0 !== 8'hB3 || {a0, a1, a2} !== 3'b000) begin
         failures++;
         $display("FAIL rstart_data: got %h ack=%b want b3 000",
                  b0, {a0, a1, a2});
      end
      checks++;
      if (busy_drop !== 0) begin
         failures++;
         $display("FAIL rstart_busy: got %0d low cycles want 0", busy_drop);
      end
   endtask

   task automatic test_reset_mid();
      logic a0, a1, a2;
      i2c_start();
      send_bits(8'h82, 1'b0);
      sda_m = 1'b1;
      #Q;
      checks++;
      if (oe0 !== 1'b1) begin
         failures++;
         $display("FAIL rstmid_ack_drive: got %b want 1", oe0);
      end
      rst = 1'b1;
      #1ns;
      checks++;
      if (oe0 !== 1'b0 || addr0 !== 6'd0 || busy0 !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_async: got oe=%b ptr=%0d busy=%b want 0 0 0",
                  oe0, addr0, busy0);
      end
      #100ns;
      rst = 1'b0;
      scl_m = 1'b1; #(2*Q);
      scl_m = 1'b0; #Q;
      i2c_stop();
      clr_mon();
      i2c_start();
      write_byte(8'h82, 1'b0, a0);
      write_byte(8'h45, 1'b0, a1);
      write_byte(8'h8A, 1'b0, a2);
      i2c_stop();
      #Q;
      checks++;
      if ({a0, a1, a2} !== 3'b000 || we_cnt !== 1 || we_a[0] !== 6'd5 ||
          we_d[0] !== 6'd10 || addr0 !== 6'd6) begin
         failures++;
         $display("FAIL rstmid_write: got ack=%b n=%0d a=%0d d=%0d ptr=%0d want 000 1 5 10 6",
                  {a0, a1, a2}, we_cnt, we_a[0], we_d[0], addr0);
      end
   endtask

   task automatic test_lsb_first();
      logic a0, a1, a2;
      sel = 1'b1;
      #Q;
      clr_mon();
      i2c_start();
      write_byte(8'h82, 1'b1, a0);
      write_byte(8'h42, 1'b1, a1);
      write_byte(8'h81, 1'b1, a2);
      i2c_stop();
      #Q;
      checks++;
      if ({a0, a1, a2} !== 3'b000 || we_cnt !== 1) begin
         failures++;
         $display("FAIL lsb_acks: got ack=%b n=%0d want 000 1",
                  {a0, a1, a2}, we_cnt);
      end
      checks++;
      if (we_a[0] !== 6'd2 || we_d[0] !== 6'd1 || addr1 !== 6'd3) begin
         failures++;
         $display("FAIL lsb_we: got a=%0d d=%0d ptr=%0d want 2 1 3",
                  we_a[0], we_d[0], addr1);
      end
      sel = 1'b0;
   endtask

   task automatic test_exclusive();
      checks++;
      if (both_hi !== 1'b0) begin
         failures++;
         $display("FAIL we_re_exclusive: got %b want 0", both_hi);
      end
   endtask

   initial begin
      clr_mon();
      test_reset();
      test_write();
      test_mismatch();
      test_wrap();
      test_read();
      test_rstart();
      test_reset_mid();
      test_lsb_first();
      test_exclusive();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
